pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//  Receive-side counterpart of the button-controlled PWM generator. Samples an external
//  PWM line, measures period and high time in clk cycles and reports duty in tenths (0..10).
//  Sits between a ui_in pin and status logic or uo_out; used for on-chip loopback of PWM_OUT.
// PARAMETERS
//  CNT_W    16    width of period/high counters and outputs
//  TIMEOUT  1000  cycles without a rising edge before the line is declared stuck (< 2^CNT_W)
//  FILT_LEN 3     consecutive equal samples needed to accept a level (glitch filter only)
// PORTS
//  clk          in  1      single clock; all state on posedge clk
//  rst_n        in  1      asynchronous, active-low reset
//  pwm_in       in  1      asynchronous PWM input
//  clr_ovr      in  1      synchronous clear of overrun
//  meas_valid   out 1      one-cycle strobe: period_out/high_out/duty_tenths/stuck updated
//  period_out   out CNT_W  cycles between last two rising edges (0 when stuck)
//  high_out     out CNT_W  cycles from rising edge to following falling edge
//  duty_tenths  out 4      floor(high*10/period), range 0..10
//  stuck        out 1      1 = last report came from timeout, not a full period
//  overrun      out 1      sticky: a measurement was dropped because the divider was busy
// BEHAVIOUR
//  - Reset: every output and register is 0; state = IDLE (unarmed).
//  - pwm_in passes a 2-FF synchronizer (s). Edges are detected on s versus its previous value.
//  - FSM IDLE -> ARMED on the first rising edge. The first edge only arms; there is no report.
//  - ARMED: per_cnt and hi_cnt both run from 1. hi_cnt freezes at the falling edge.
//    Counters saturate at 2^CNT_W-1 and never wrap.
//  - Rising edge in ARMED: period/high are latched into the divider and the counters restart.
//    FSM -> DIV. Counting continues during DIV.
//  - DIV: restoring division of high*10 (CNT_W+4 bits) by period. It produces a 4-bit quotient,
//    1 bit/cycle, 4 cycles.
//    The cycle after the last bit: meas_valid=1, outputs update, stuck=0, FSM -> ARMED.
//    Latency = 5 cycles from the synchronized rising edge.
//  - Rising edge during DIV: that measurement is dropped and overrun is set. The counters still
//    restart, so the next period is measured correctly. The divider does not restart.
//  - clr_ovr clears overrun. If clr_ovr and a new overrun occur in the same cycle, set wins.
//  - Timeout: if per_cnt reaches TIMEOUT in ARMED or IDLE, the module reports:
//    meas_valid=1, stuck=1, period_out=0, high_out=0, duty_tenths = s ? 10 : 0.
//    FSM -> IDLE. It reports once, not again until re-armed and timed out again.
//    In IDLE, per_cnt counts from reset or from the last report.
//  - duty_tenths is capped at 10 (this can only be exceeded by corrupt input).
//  - A rising and falling edge can never coincide on s. A pulse of 1 cycle high gives high_out=1.
//  - An rst_n assertion mid-DIV aborts the division. No meas_valid is produced.
// CONFIGURATION
//  PWM_DEC_GLITCH_FILTER_EN defined:
//   - s feeds a debounce stage. The filtered level changes only after FILT_LEN equal consecutive
//     samples, which adds FILT_LEN cycles of latency.
//   - Pulses shorter than FILT_LEN cycles are ignored.
//  Undefined: filter absent. Edges are taken directly from the synchronizer output.
// STRUCTURE
//  - Package pwm_dec_pkg: FSM state enum {IDLE, ARMED, DIV}, the DUTY_MAX=10 constant, and the
//    DUTY_W=4 constant.
//  - Sub-module pwm_dec_div: 4-iteration restoring divider with ports start/busy/done.
//    Its inputs are dividend[CNT_W+3:0] and divisor[CNT_W-1:0]; its output is q[3:0].
//  - The top level holds the synchronizer, the optional filter, the counters, the FSM, and the
//    output registers.
// TESTING
//  1. Period 10, high 5 (generator default) -> after the 2nd rise: period_out=10, high_out=5,
//     duty_tenths=5, stuck=0. Repeats every 10 cycles.
//  2. Duty stepped 5->9 then 1 (period 10) -> duty_tenths 9 then 1; high_out 9 then 1.
//  3. pwm_in held 0 (duty 0) after arming, TIMEOUT=1000 -> a single meas_valid with stuck=1 and
//     duty_tenths=0. A held 1 gives duty_tenths=10.
//  4. Period 4 (rises during DIV) -> overrun=1, and reports occur only for every other period.
//     clr_ovr=1 for 1 cycle -> overrun=0.
//  5. rst_n pulsed low during DIV -> all outputs 0 asynchronously and no strobe. The first rise
//     after release only arms.
//  6. With PWM_DEC_GLITCH_FILTER_EN: a 1-cycle high glitch on a low line -> no arm and no report.
//     A 3-cycle pulse is accepted.

Source files
------------

// File: rtl/pwm_dec_pkg.sv
// Shared types and constants for the PWM duty decoder.
package pwm_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DIV
  } state_t;

  localparam int unsigned DUTY_MAX = 10;
  localparam int unsigned DUTY_W   = 4;

  function automatic logic [DUTY_W-1:0] cap_duty(input logic [DUTY_W-1:0] q);
    return (q > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : q;
  endfunction

endpackage

// File: rtl/pwm_dec_div.sv
// Four-iteration restoring divider: one quotient bit per cycle, MSB first.
// done is asserted during the last iteration, with q already holding all four bits.
module pwm_dec_div #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W+3:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [3:0]       q
);

  logic [CNT_W+3:0] rem;
  logic [CNT_W-1:0] dvs;
  logic [2:0]       q_hi;
  logic [1:0]       step;
  logic [CNT_W+4:0] shifted;
  logic [CNT_W+4:0] trial;
  logic             bit_now;

  always_comb begin
    shifted = {5'b0, dvs} << (2'd3 - step);
    trial   = {1'b0, rem} - shifted;
    bit_now = ~trial[CNT_W+4];
    done    = busy && (step == 2'd3);
    q       = {q_hi, bit_now};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      dvs  <= '0;
      q_hi <= '0;
      step <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      if (bit_now) rem <= trial[CNT_W+3:0];
      q_hi <= {q_hi[1:0], bit_now};
      step <= step + 2'd1;
      if (step == 2'd3) busy <= 1'b0;
    end else if (start) begin
      rem  <= dividend;
      dvs  <= divisor;
      q_hi <= '0;
      step <= '0;
      busy <= 1'b1;
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures period/high time of an external PWM line and reports duty in tenths.
// Optional glitch filter on the synchronized line: define PWM_DEC_GLITCH_FILTER_EN.
module pwm_duty_decoder
  import pwm_dec_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  input  logic              clr_ovr,
  output logic              meas_valid,
  output logic [CNT_W-1:0]  period_out,
  output logic [CNT_W-1:0]  high_out,
  output logic [DUTY_W-1:0] duty_tenths,
  output logic              stuck,
  output logic              overrun
);

  if (TIMEOUT >= (64'd1 << CNT_W) || FILT_LEN < 1) begin : g_bad_params
    $error("pwm_duty_decoder: TIMEOUT must be < 2**CNT_W and FILT_LEN >= 1");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  logic s1, s;
  logic lvl, lvl_prev;
  logic rise, fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s  <= s1;
    end
  end

`ifdef PWM_DEC_GLITCH_FILTER_EN
  localparam int unsigned FC_W = $clog2(FILT_LEN) + 1;
  logic [FC_W-1:0] fcnt;

  // fcnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl  <= 1'b0;
      fcnt <= '0;
    end else if (s == lvl) begin
      fcnt <= '0;
    end else if (fcnt == FC_W'(FILT_LEN - 1)) begin
      lvl  <= s;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end
`else
  always_comb lvl = s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_prev <= 1'b0;
    else        lvl_prev <= lvl;
  end

  assign rise = lvl & ~lvl_prev;
  assign fall = ~lvl & lvl_prev;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] per_lat, hi_lat;
  logic             hi_run;
  logic             timed_out;
  logic             tmo_cond, tmo_hit, div_start, ovr_set;
  logic             div_busy, div_done;
  logic [3:0]       div_q;
  logic [CNT_W+3:0] dividend;

  assign dividend = ({4'b0, hi_cnt} << 3) + ({4'b0, hi_cnt} << 1);
  assign tmo_cond = !timed_out && (per_cnt == TMO);

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    ovr_set   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (rise)          state_nxt = ARMED;
        else if (tmo_cond) tmo_hit   = 1'b1;
      end
      ARMED: begin
        if (rise) begin
          if (div_busy) begin
            ovr_set = 1'b1;
          end else begin
            div_start = 1'b1;
            state_nxt = DIV;
          end
        end else if (tmo_cond) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV: begin
        if (rise)     ovr_set   = 1'b1;
        if (div_done) state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Counters restart on every rise, including dropped ones, so the next period stays valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt   <= '0;
      hi_cnt    <= '0;
      hi_run    <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      if (rise)                    per_cnt <= CNT_W'(1);
      else if (tmo_hit)            per_cnt <= '0;
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 1'b1;

      if (rise) begin
        hi_cnt <= CNT_W'(1);
        hi_run <= 1'b1;
      end else if (fall) begin
        hi_run <= 1'b0;
      end else if (hi_run && hi_cnt != CNT_MAX) begin
        hi_cnt <= hi_cnt + 1'b1;
      end

      if (rise)         timed_out <= 1'b0;
      else if (tmo_hit) timed_out <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_lat <= '0;
      hi_lat  <= '0;
    end else if (div_start) begin
      per_lat <= per_cnt;
      hi_lat  <= hi_cnt;
    end
  end

  pwm_dec_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (per_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .q        (div_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid  <= 1'b0;
      period_out  <= '0;
      high_out    <= '0;
      duty_tenths <= '0;
      stuck       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (div_done) begin
        meas_valid  <= 1'b1;
        period_out  <= per_lat;
        high_out    <= hi_lat;
        duty_tenths <= cap_duty(div_q);
        stuck       <= 1'b0;
      end else if (tmo_hit) begin
        meas_valid  <= 1'b1;
        period_out  <= '0;
        high_out    <= '0;
        duty_tenths <= lvl ? DUTY_W'(DUTY_MAX) : '0;
        stuck       <= 1'b1;
      end

      if (ovr_set)      overrun <= 1'b1;
      else if (clr_ovr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized bench for pwm_duty_decoder with a timestamp-based reference model.
module tb_pwm_duty_decoder;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 1000;
  localparam int FILT_LEN = 3;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic             clr_ovr = 1'b0;
  logic             meas_valid;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic [3:0]       duty_tenths;
  logic             stuck;
  logic             overrun;

  pwm_duty_decoder #(
    .CNT_W    (CNT_W),
    .TIMEOUT  (TIMEOUT),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .clr_ovr     (clr_ovr),
    .meas_valid  (meas_valid),
    .period_out  (period_out),
    .high_out    (high_out),
    .duty_tenths (duty_tenths),
    .stuck       (stuck),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: event timestamps (edge indices) instead of counters
  int k, ref_e, rise_e, fall_e, div_start, due;
  bit m_s1, m_s, m_sp, armed, fell, tmo;
  int p_per, p_hi, p_duty;
  int e_valid, e_per, e_hi, e_duty, e_stuck, e_ovr;
`ifdef PWM_DEC_GLITCH_FILTER_EN
  bit m_f, m_fp;
  bit hist [FILT_LEN];
`endif

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic model_reset();
    k = 0; ref_e = 0; rise_e = 0; fall_e = 0; div_start = -100; due = -1;
    m_s1 = 0; m_s = 0; m_sp = 0; armed = 0; fell = 0; tmo = 0;
    p_per = 0; p_hi = 0; p_duty = 0;
    e_valid = 0; e_per = 0; e_hi = 0; e_duty = 0; e_stuck = 0; e_ovr = 0;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    m_f = 0; m_fp = 0;
    for (int i = 0; i < FILT_LEN; i++) hist[i] = 0;
`endif
  endtask

  task automatic model_step();
    bit lvl, prv, rise, fall, dividing, drop, all_diff;
    int per, hi;
`ifdef PWM_DEC_GLITCH_FILTER_EN
    lvl = m_f; prv = m_fp;
`else
    lvl = m_s; prv = m_sp;
`endif
    rise     = lvl && !prv;
    fall     = !lvl && prv;
    dividing = armed && k >= div_start + 1 && k <= div_start + 4;
    per      = sat(k - ref_e);
    hi       = fell ? sat(fall_e - rise_e) : sat(k - rise_e);
    e_valid  = 0;
    drop     = 0;
    if (due == k) begin
      e_valid = 1; e_per = p_per; e_hi = p_hi; e_duty = p_duty; e_stuck = 0; due = -1;
    end
    if (rise) begin
      if (!armed) armed = 1;
      else if (dividing) drop = 1;
      else begin
        p_per = per; p_hi = hi;
        p_duty = (hi * 10) / per;
        if (p_duty > 10) p_duty = 10;
        due = k + 4; div_start = k;
      end
      rise_e = k; ref_e = k; fell = 0; tmo = 0;
    end else begin
      if (fall) begin fell = 1; fall_e = k; end
      if (!dividing && !tmo && per == TIMEOUT) begin
        e_valid = 1; e_stuck = 1; e_per = 0; e_hi = 0; e_duty = lvl ? 10 : 0;
        armed = 0; ref_e = k + 1; tmo = 1;
      end
    end
    e_ovr = drop ? 1 : (clr_ovr ? 0 : e_ovr);
`ifdef PWM_DEC_GLITCH_FILTER_EN
    for (int i = FILT_LEN - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = m_s;
    all_diff = 1;
    for (int i = 0; i < FILT_LEN; i++) if (hist[i] == m_f) all_diff = 0;
    m_fp = m_f;
    if (all_diff) m_f = m_s;
`else
    all_diff = 0;
`endif
    m_sp = m_s; m_s = m_s1; m_s1 = pwm_in;
    k++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  int rep_cnt = 0;
  int r_per, r_hi, r_duty, r_stuck;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("meas_valid",  int'(meas_valid),  e_valid);
      chk("period_out",  int'(period_out),  e_per);
      chk("high_out",    int'(high_out),    e_hi);
      chk("duty_tenths", int'(duty_tenths), e_duty);
      chk("stuck",       int'(stuck),       e_stuck);
      chk("overrun",     int'(overrun),     e_ovr);
      if (meas_valid) begin
        rep_cnt++;
        r_per = int'(period_out); r_hi = int'(high_out);
        r_duty = int'(duty_tenths); r_stuck = int'(stuck);
      end
    end
  end

  bit rand_clr = 0;

  task automatic cyc();
    @(negedge clk);
    #1;
    clr_ovr = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
  endtask

  task automatic pwm_periods(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (hi) cyc();
      pwm_in = 1'b0;
      repeat (per - hi) cyc();
    end
  endtask

  task automatic hold(input bit lv, input int n);
    pwm_in = lv;
    repeat (n) cyc();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cyc();
    rst_n = 1'b1;
  endtask

  task automatic chk_report(input string tag, input int per, input int hi, input int duty, input int stk);
    chk({tag, "_period"}, r_per, per);
    chk({tag, "_high"},   r_hi, hi);
    chk({tag, "_duty"},   r_duty, duty);
    chk({tag, "_stuck"},  r_stuck, stk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst_n = 1'b0;
    #23;
    chk("rst_valid",  int'(meas_valid), 0);
    chk("rst_period", int'(period_out), 0);
    chk("rst_duty",   int'(duty_tenths), 0);
    chk("rst_ovr",    int'(overrun), 0);
    cyc();
    rst_n = 1'b1;
    repeat (3) cyc();

    // 10/5: first rise only arms, then one report per period
    c0 = rep_cnt;
    pwm_periods(10, 5, 6);
    chk("p1_count", rep_cnt - c0, 5);
    chk_report("p1", 10, 5, 5, 0);

    pwm_periods(10, 9, 3);
    chk_report("p2a", 10, 9, 9, 0);
    pwm_periods(10, 1, 3);
    chk_report("p2b", 10, 1, 1, 0);

    c0 = rep_cnt;
    hold(1'b0, 1100);
    chk("p3_low_count", rep_cnt - c0, 1);
    chk_report("p3_low", 0, 0, 0, 1);
    c0 = rep_cnt;
    hold(1'b1, 1100);
    chk("p3_high_count", rep_cnt - c0, 1);
    chk_report("p3_high", 0, 0, 10, 1);
    hold(1'b0, 5);

    c0 = rep_cnt;
    pwm_periods(4, 2, 8);
    hold(1'b0, 10);
    chk("p4_count", rep_cnt - c0, 4);
    chk_report("p4", 4, 2, 5, 0);
    chk("p4_overrun", int'(overrun), 1);
    clr_ovr = 1'b1;
    cyc();
    clr_ovr = 1'b0;
    chk("p4_overrun_clr", int'(overrun), 0);

    pwm_periods(10, 5, 3);
    pwm_in = 1'b1;
    repeat (4) cyc();
    rst_n = 1'b0;
    #1;
    chk("p5_async_valid",  int'(meas_valid), 0);
    chk("p5_async_period", int'(period_out), 0);
    chk("p5_async_high",   int'(high_out), 0);
    chk("p5_async_duty",   int'(duty_tenths), 0);
    repeat (3) cyc();
    rst_n = 1'b1;
    c0 = rep_cnt;
    repeat (4) cyc();
    pwm_in = 1'b0;
    repeat (5) cyc();
    chk("p5_arm_only", rep_cnt - c0, 0);

    rand_clr = 1;
    for (int b = 0; b < 60; b++) begin
      int sel, per, hi;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        hold(1'($urandom_range(0, 1)), $urandom_range(1005, 1100));
      end else if (sel == 1) begin
        do_reset($urandom_range(1, 3));
      end else begin
        per = $urandom_range(2, 24);
        hi  = $urandom_range(1, per - 1);
        pwm_periods(per, hi, $urandom_range(1, 6));
      end
    end
    rand_clr = 0;
    hold(1'b0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
